adc_spi_responder: RTL and testbench



---
 rtl/adc_spi_responder_if.sv | 22 ++
 rtl/adc_spi_responder.sv | 184 ++++++++++++++++++
 tb/tb_adc_spi_responder.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_spi_responder_if.sv
// SPI-side pins of the ADC responder: conversion strobe and serial clock
// from the master, serial data and its drive-enable back to the master.
interface adc_spi_responder_if;
  logic ad_conv;
  logic spi_sck;
  logic spi_miso;
  logic miso_oe;

  modport master (
    output ad_conv,
    output spi_sck,
    input  spi_miso,
    input  miso_oe
  );

  modport slave (
    input  ad_conv,
    input  spi_sck,
    output spi_miso,
    output miso_oe
  );
endinterface

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: slave-side model of a two-channel sampling ADC serial
// port. A conversion strobe latches the held samples into a frame, which is
// then shifted out on MISO one slot per detected SCK falling edge:
//   LEAD high-Z, channel A MSB first, LEAD high-Z, channel B MSB first, TAIL high-Z.
// SCK and AD_CONV are asynchronous and are synchronized into clk.
// SYNC_STAGES must be at least 2.
// Optional build macro ADC_RESP_STATS_EN adds frame_count / overrun_count.
module adc_spi_responder #(
  parameter int DATA_W      = 14,
  parameter int LEAD_BITS   = 2,
  parameter int TAIL_BITS   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  adc_spi_responder_if.slave  spi,
  input  logic [DATA_W-1:0]   sample_a,
  input  logic [DATA_W-1:0]   sample_b,
  input  logic                sample_valid,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun,
  output logic                stale
`ifdef ADC_RESP_STATS_EN
  ,
  output logic [15:0]         frame_count,
  output logic [15:0]         overrun_count
`endif
);

  localparam int FRAME_BITS = 2*LEAD_BITS + 2*DATA_W + TAIL_BITS;
  localparam int POS_W      = $clog2(FRAME_BITS + 1);

  // Slot boundaries; the *_END values are exclusive.
  localparam logic [POS_W-1:0] A_FIRST   = POS_W'(LEAD_BITS);
  localparam logic [POS_W-1:0] A_END     = POS_W'(LEAD_BITS + DATA_W);
  localparam logic [POS_W-1:0] B_FIRST   = POS_W'(2*LEAD_BITS + DATA_W);
  localparam logic [POS_W-1:0] B_END     = POS_W'(2*LEAD_BITS + 2*DATA_W);
  localparam logic [POS_W-1:0] LAST_POS  = POS_W'(FRAME_BITS - 1);
  localparam logic [POS_W-1:0] FRAME_END = POS_W'(FRAME_BITS);
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] conv_sync;
  logic                   sck_d;
  logic                   conv_d;
  logic                   sck_fall;
  logic                   conv_rise;

  logic [POS_W-1:0]  bit_pos;
  logic [DATA_W-1:0] hold_a;
  logic [DATA_W-1:0] hold_b;
  logic              fresh;
  logic [DATA_W-1:0] sh_a;
  logic [DATA_W-1:0] sh_b;
  logic              in_a;
  logic              in_b;
  logic              miso_q;
  logic              oe_q;

  assign sck_fall  = sck_d & ~sck_sync[SYNC_STAGES-1];
  assign conv_rise = conv_sync[SYNC_STAGES-1] & ~conv_d;

  assign in_a = (bit_pos >= A_FIRST) && (bit_pos < A_END);
  assign in_b = (bit_pos >= B_FIRST) && (bit_pos < B_END);

  assign busy         = (state == SHIFT);
  assign frame_done   = (state == DONE);
  assign spi.spi_miso = miso_q;
  assign spi.miso_oe  = oe_q;

  // Bring SCK and AD_CONV into clk, keeping one extra flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync  <= '0;
      conv_sync <= '0;
      sck_d     <= 1'b0;
      conv_d    <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi.spi_sck};
      conv_sync <= {conv_sync[SYNC_STAGES-2:0], spi.ad_conv};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      conv_d    <= conv_sync[SYNC_STAGES-1];
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A conversion edge (re)starts a frame from any state; the last SCK fall ends it.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (conv_rise) next_state = SHIFT;
      SHIFT: begin
        if (conv_rise) begin
          next_state = SHIFT;
        end else if (sck_fall && (bit_pos == LAST_POS)) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = conv_rise ? SHIFT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Holding register, frame load on conversion, and slot advance on SCK falls.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_a  <= '0;
      hold_b  <= '0;
      fresh   <= 1'b0;
      sh_a    <= '0;
      sh_b    <= '0;
      stale   <= 1'b0;
      overrun <= 1'b0;
      bit_pos <= '0;
    end else begin
      overrun <= 1'b0;
      if (sample_valid) begin
        hold_a <= sample_a;
        hold_b <= sample_b;
        fresh  <= 1'b1;
      end
      if (conv_rise) begin
        sh_a    <= sample_valid ? sample_a : hold_a;
        sh_b    <= sample_valid ? sample_b : hold_b;
        stale   <= ~(sample_valid | fresh);
        fresh   <= 1'b0;
        bit_pos <= '0;
        overrun <= (state == SHIFT);
      end else if ((state == SHIFT) && sck_fall) begin
        if (bit_pos != FRAME_END) begin
          bit_pos <= bit_pos + POS_ONE;
        end
        if (in_a) begin
          sh_a <= {sh_a[DATA_W-2:0], 1'b0};
        end
        if (in_b) begin
          sh_b <= {sh_b[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  // Registered MISO slot: driven data in channel slots, released elsewhere.
  always_ff @(posedge clk) begin
    if (reset || (state != SHIFT)) begin
      oe_q   <= 1'b0;
      miso_q <= 1'b0;
    end else begin
      oe_q   <= in_a | in_b;
      miso_q <= in_a ? sh_a[DATA_W-1] : (in_b ? sh_b[DATA_W-1] : 1'b0);
    end
  end

`ifdef ADC_RESP_STATS_EN
  // Free-running event counters; they wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count   <= '0;
      overrun_count <= '0;
    end else begin
      if (frame_done) begin
        frame_count <= frame_count + 16'd1;
      end
      if (overrun) begin
        overrun_count <= overrun_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adc_spi_responder.sv
// Testbench for adc_spi_responder: drives directed SPI frames, pushes the
// expected MISO slot stream into a queue, and a monitor pops and compares
// one slot on every SCK rising edge (mid-slot, well after MISO has settled).
module tb_adc_spi_responder;

  localparam int DW   = 14;
  localparam int HALF = 8;

  typedef struct packed {
    logic oe;
    logic d;
  } slot_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] sample_a;
  logic [DW-1:0] sample_b;
  logic          sample_valid;
  logic          busy;
  logic          frame_done;
  logic          overrun;
  logic          stale;
`ifdef ADC_RESP_STATS_EN
  logic [15:0]   frame_count;
  logic [15:0]   overrun_count;
`endif

  slot_t exp_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;
  int    slot_idx     = 0;
  int    done_cnt     = 0;
  int    ovr_cnt      = 0;

  adc_spi_responder_if bus();

  adc_spi_responder #(
    .DATA_W(DW),
    .LEAD_BITS(2),
    .TAIL_BITS(2),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .spi(bus),
    .sample_a(sample_a),
    .sample_b(sample_b),
    .sample_valid(sample_valid),
    .busy(busy),
    .frame_done(frame_done),
    .overrun(overrun),
    .stale(stale)
`ifdef ADC_RESP_STATS_EN
    ,
    .frame_count(frame_count),
    .overrun_count(overrun_count)
`endif
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: one expected slot consumed per SCK rising edge.
  always @(posedge bus.spi_sck) begin : monitor
    slot_t got;
    slot_t want;
    got = {bus.miso_oe, bus.spi_miso};
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL slot%0d: got oe/miso %b, expected nothing queued",
               slot_idx, got);
    end else begin
      want = exp_q.pop_front();
      checkOutput($sformatf("slot%0d", slot_idx), 16'(got), 16'(want));
    end
    slot_idx++;
  end

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (overrun)    ovr_cnt++;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sckCycles(input int n);
    repeat (n) begin
      bus.spi_sck = 1'b1;
      waitClk(HALF);
      bus.spi_sck = 1'b0;
      waitClk(HALF);
    end
  endtask

  task automatic pushIdle(input int n);
    repeat (n) exp_q.push_back(2'b00);
  endtask

  // Expected frame: 2 Z, A MSB first, 2 Z, B MSB first, 2 Z; first 'count' slots.
  task automatic pushFrame(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input int count);
    slot_t f[$];
    for (int i = 0; i < 2; i++) f.push_back(2'b00);
    for (int i = DW-1; i >= 0; i--) f.push_back({1'b1, a[i[3:0]]});
    for (int i = 0; i < 2; i++) f.push_back(2'b00);
    for (int i = DW-1; i >= 0; i--) f.push_back({1'b1, b[i[3:0]]});
    for (int i = 0; i < 2; i++) f.push_back(2'b00);
    for (int k = 0; k < count; k++) exp_q.push_back(f[k]);
  endtask

  // Optionally load a sample pair, then pulse the conversion strobe.
  task automatic applyStimulus(input logic load, input logic [DW-1:0] a,
                               input logic [DW-1:0] b);
    if (load) begin
      sample_a     = a;
      sample_b     = b;
      sample_valid = 1'b1;
      waitClk(1);
      sample_valid = 1'b0;
    end
    bus.ad_conv = 1'b1;
    waitClk(4);
    bus.ad_conv = 1'b0;
    waitClk(6);
  endtask

  initial begin
    reset        = 1'b1;
    sample_a     = '0;
    sample_b     = '0;
    sample_valid = 1'b0;
    bus.ad_conv  = 1'b0;
    bus.spi_sck  = 1'b0;
    waitClk(3);
    reset = 1'b0;
    waitClk(2);

    checkOutput("rst_miso_oe",    16'(bus.miso_oe),  16'd0);
    checkOutput("rst_spi_miso",   16'(bus.spi_miso), 16'd0);
    checkOutput("rst_busy",       16'(busy),         16'd0);
    checkOutput("rst_frame_done", 16'(frame_done),   16'd0);
    checkOutput("rst_overrun",    16'(overrun),      16'd0);
    checkOutput("rst_stale",      16'(stale),        16'd0);

    // SCK in IDLE is ignored.
    pushIdle(3);
    sckCycles(3);
    checkOutput("idle_busy", 16'(busy), 16'd0);

    // Normal frame: A=1ABC -> 01101010111100, B=0123 -> 00000100100011.
    applyStimulus(1'b1, 14'h1ABC, 14'h0123);
    checkOutput("normal_stale", 16'(stale), 16'd0);
    checkOutput("normal_busy",  16'(busy),  16'd1);
    pushFrame(14'h1ABC, 14'h0123, 34);
    sckCycles(34);
    checkOutput("normal_done_cnt", 16'(done_cnt), 16'd1);
    checkOutput("normal_busy_end", 16'(busy),     16'd0);
    checkOutput("normal_ovr_cnt",  16'(ovr_cnt),  16'd0);

    // Stale: same sample sent again.
    applyStimulus(1'b0, '0, '0);
    checkOutput("stale_flag", 16'(stale), 16'd1);
    pushFrame(14'h1ABC, 14'h0123, 34);
    sckCycles(34);
    checkOutput("stale_done_cnt", 16'(done_cnt), 16'd2);

    // Mid-frame restart after 10 falls with A=3FFF loaded.
    applyStimulus(1'b0, '0, '0);
    pushFrame(14'h1ABC, 14'h0123, 10);
    sckCycles(10);
    applyStimulus(1'b1, 14'h3FFF, 14'h0123);
    checkOutput("restart_ovr_cnt",  16'(ovr_cnt),  16'd1);
    checkOutput("restart_stale",    16'(stale),    16'd0);
    checkOutput("restart_busy",     16'(busy),     16'd1);
    checkOutput("restart_no_done",  16'(done_cnt), 16'd2);
    pushFrame(14'h3FFF, 14'h0123, 34);
    sckCycles(34);
    checkOutput("restart_done_cnt", 16'(done_cnt), 16'd3);
    checkOutput("restart_ovr_end",  16'(ovr_cnt),  16'd1);

    // Conversion edge in the same cycle as an SCK fall: restart wins.
    applyStimulus(1'b1, 14'h2AAA, 14'h1555);
    pushFrame(14'h2AAA, 14'h1555, 6);
    sckCycles(5);
    bus.spi_sck = 1'b1;
    waitClk(HALF);
    bus.spi_sck = 1'b0;
    bus.ad_conv = 1'b1;
    waitClk(4);
    bus.ad_conv = 1'b0;
    waitClk(4);
    checkOutput("same_cycle_ovr",   16'(ovr_cnt), 16'd2);
    checkOutput("same_cycle_stale", 16'(stale),   16'd1);
    pushFrame(14'h2AAA, 14'h1555, 34);
    sckCycles(34);
    checkOutput("same_cycle_done", 16'(done_cnt), 16'd4);

    // ad_conv held high: one frame only; SCK after DONE ignored.
    sample_a     = 14'h0F0F;
    sample_b     = 14'h30F0;
    sample_valid = 1'b1;
    waitClk(1);
    sample_valid = 1'b0;
    bus.ad_conv  = 1'b1;
    waitClk(100);
    pushFrame(14'h0F0F, 14'h30F0, 34);
    sckCycles(34);
    checkOutput("held_done_cnt", 16'(done_cnt), 16'd5);
    checkOutput("held_ovr_cnt",  16'(ovr_cnt),  16'd2);
    pushIdle(2);
    sckCycles(2);
    bus.ad_conv = 1'b0;
    waitClk(4);
    checkOutput("held_busy_end", 16'(busy),     16'd0);
    checkOutput("held_done_end", 16'(done_cnt), 16'd5);

    // Reset after 20 falls: frame lost, later SCK produces nothing.
    applyStimulus(1'b1, 14'h1234, 14'h0567);
    pushFrame(14'h1234, 14'h0567, 20);
    sckCycles(20);
    reset = 1'b1;
    waitClk(1);
    checkOutput("midrst_miso_oe",    16'(bus.miso_oe), 16'd0);
    checkOutput("midrst_busy",       16'(busy),        16'd0);
    checkOutput("midrst_frame_done", 16'(frame_done),  16'd0);
    checkOutput("midrst_stale",      16'(stale),       16'd0);
    reset = 1'b0;
    waitClk(2);
    pushIdle(3);
    sckCycles(3);
    checkOutput("midrst_busy_after", 16'(busy),     16'd0);
    checkOutput("midrst_done_cnt",   16'(done_cnt), 16'd5);

    // Three complete frames plus one overrun.
    applyStimulus(1'b1, 14'h0AAA, 14'h0555);
    pushFrame(14'h0AAA, 14'h0555, 3);
    sckCycles(3);
    applyStimulus(1'b0, '0, '0);
    pushFrame(14'h0AAA, 14'h0555, 34);
    sckCycles(34);
    repeat (2) begin
      applyStimulus(1'b0, '0, '0);
      pushFrame(14'h0AAA, 14'h0555, 34);
      sckCycles(34);
    end
    checkOutput("stats_done_cnt", 16'(done_cnt), 16'd8);
    checkOutput("stats_ovr_cnt",  16'(ovr_cnt),  16'd3);
`ifdef ADC_RESP_STATS_EN
    checkOutput("frame_count",   frame_count,   16'd3);
    checkOutput("overrun_count", overrun_count, 16'd1);
`endif

    checkOutput("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
